// File: rtl/vga_timing_gen.sv
// VGA sync/counter generator: pixel-rate divider, h/v counters, registered syncs.
// Define VGA_PIXEL_DIV4_EN for a divide-by-4 pixel enable (default divide-by-2).
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_tick
);

`ifdef VGA_PIXEL_DIV4_EN
   localparam int               DIV_W   = 2;
   localparam logic [DIV_W-1:0] DIV_MAX = 2'd3;
`else
   localparam int               DIV_W   = 1;
   localparam logic [DIV_W-1:0] DIV_MAX = 1'd1;
`endif

   localparam logic [9:0] H_DISP  = 10'(H_DISPLAY);
   localparam logic [9:0] H_MAX   = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_LO   = 10'(H_DISPLAY + H_FP);
   localparam logic [9:0] HS_HI   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_DISP  = 10'(V_DISPLAY);
   localparam logic [9:0] V_MAX   = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_LO   = 10'(V_DISPLAY + V_FP);
   localparam logic [9:0] VS_HI   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_next;
   logic [9:0]       h_q, h_next;
   logic [9:0]       v_q, v_next;
   logic             hsync_q, vsync_q;
   logic             h_last, v_last;

   assign p_tick = (div_q == DIV_MAX);
   assign h_last = (h_q == H_MAX);
   assign v_last = (v_q == V_MAX);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      div_next = div_q + 1'b1;
      h_next   = h_q;
      v_next   = v_q;
      if (p_tick) begin
         div_next = '0;
         h_next   = h_last ? 10'd0 : h_q + 10'd1;
         // v and h wrap on the same edge, so (0,0) follows (H_MAX,V_MAX) directly
         if (h_last)
            v_next = v_last ? 10'd0 : v_q + 10'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         div_q   <= div_next;
         h_q     <= h_next;
         v_q     <= v_next;
         // syncs decode the next count so they line up with pixel_x/pixel_y
         hsync_q <= !((h_next >= HS_LO) && (h_next <= HS_HI));
         vsync_q <= !((v_next >= VS_LO) && (v_next <= VS_HI));
      end
   end

   assign pixel_x    = h_q;
   assign pixel_y    = v_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = (h_q < H_DISP) && (v_q < V_DISP);
   assign frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster; expected outputs are
// derived from the number of clock edges since reset release.
module tb_vga_timing_gen;

   localparam int HD = 16, HF = 4, HS = 6, HB = 4;
   localparam int VD = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
`ifdef VGA_PIXEL_DIV4_EN
   localparam int N = 4;
`else
   localparam int N = 2;
`endif
   localparam int FRAME_CLKS = HT * VT * N;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       hsync, vsync, video_on, p_tick, frame_tick;
   logic [9:0] pixel_x, pixel_y;

   int total = 0;
   int bad   = 0;
   int k     = 0;   // rising edges since reset release

   vga_timing_gen #(
      .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hsync     (hsync),
      .vsync     (vsync),
      .video_on  (video_on),
      .p_tick    (p_tick),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d (k=%0d)", tag, observed, expected, k);
      end
   endtask

   // Position is just the completed pixel-tick count laid out on the raster.
   task automatic check_all(input string tag);
      int p, x, y;
      bit pt, hs, vs;
      p  = (k / N) % (HT * VT);
      x  = p % HT;
      y  = p / HT;
      pt = (k % N) == (N - 1);
      hs = !(x >= HD + HF && x < HD + HF + HS);
      vs = !(y >= VD + VF && y < VD + VF + VS);
      check({tag, ".x"},     int'(pixel_x),    x);
      check({tag, ".y"},     int'(pixel_y),    y);
      check({tag, ".ptick"}, int'(p_tick),     int'(pt));
      check({tag, ".hsync"}, int'(hsync),      int'(hs));
      check({tag, ".vsync"}, int'(vsync),      int'(vs));
      check({tag, ".von"},   int'(video_on),   int'(x < HD && y < VD));
      check({tag, ".ftick"}, int'(frame_tick), int'(pt && x == HT - 1 && y == VT - 1));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (reset) k++;
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      int hs_low, ft_cnt, last_ft, n_steps, hold;
      bit found;

      // reset held low from time 0
      repeat (3) step("rst");
      check("rst.x0",     int'(pixel_x), 0);
      check("rst.hsync1", int'(hsync), 1);
      check("rst.von1",   int'(video_on), 1);

      // release and run three frames, counting hsync-low ticks on the first line
      reset = 1'b1;
      k = 0;
      hs_low = 0; ft_cnt = 0; last_ft = -1;
      for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
         step("run");
         if (i == 0) check("first_ptick", int'(p_tick), int'(N == 2));
         if (i < HT * N && p_tick && !hsync) hs_low++;
         if (frame_tick) begin
            ft_cnt++;
            check("ft_x", int'(pixel_x), HT - 1);
            check("ft_y", int'(pixel_y), VT - 1);
            if (last_ft >= 0) check("ft_gap", k - last_ft, FRAME_CLKS);
            last_ft = k;
         end
      end
      check("hsync_low_ticks", hs_low, HS);
      check("frame_tick_cnt", ft_cnt, 3);
      step("wrap");
      check("wrap_x", int'(pixel_x), 0);
      check("wrap_y", int'(pixel_y), 0);

      // mid-hsync asynchronous reset on line 5
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
         step("seek");
         if (pixel_y == 10'd5 && pixel_x == 10'(HD + HF + 2)) found = 1'b1;
      end
      check("seek_found", int'(found), 1);
      check("mid_hsync_low", int'(hsync), 0);
      #1 reset = 1'b0;
      k = 0;
      #1;
      check("async_x", int'(pixel_x), 0);
      check("async_y", int'(pixel_y), 0);
      check("async_hsync", int'(hsync), 1);
      check_all("async");
      repeat (2) step("hold");
      @(negedge clk);
      reset = 1'b1;
      repeat (2 * HT * N) step("resume");

      // random run lengths, random async reset pulses
      for (int r = 0; r < 6; r++) begin
         n_steps = $urandom_range(1, 3 * HT * N + 200);
         repeat (n_steps) step("rnd");
         #($urandom_range(1, 3)) reset = 1'b0;
         k = 0;
         #1 check_all("rnd_async");
         hold = $urandom_range(1, 3);
         repeat (hold) step("rnd_hold");
         reset = 1'b1;
      end
      repeat (HT * N) step("tail");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
